// File: rtl/wb_unit_if.sv
// Shared pipeline types and the writeback-stage bus interface.
// o_instret exists only when WB_INSTRET_EN is defined.
package wb_unit_pkg;
    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] reg_data_t;

    typedef enum logic [3:0] {
        EXCEPT_NONE          = 4'd0,
        EXCEPT_IADDR_MISALIGN = 4'd1,
        EXCEPT_ILLEGAL       = 4'd2,
        EXCEPT_BREAKPOINT    = 4'd3,
        EXCEPT_LOAD_MISALIGN = 4'd4,
        EXCEPT_LOAD_FAULT    = 4'd5,
        EXCEPT_STORE_MISALIGN = 4'd6,
        EXCEPT_STORE_FAULT   = 4'd7,
        EXCEPT_ECALL         = 4'd8,
        EXCEPT_MISPRED       = 4'd15
    } except_code_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wb_rd;
    } decode_t;

    typedef struct packed {
        logic         valid;
        except_code_t code;
    } except_t;

    typedef struct packed {
        logic      valid;
        reg_data_t pc;
        decode_t   decode;
        except_t   except;
    } issued_instr_t;
endpackage

interface wb_unit_if #(parameter int unsigned XLEN = 64);
    import wb_unit_pkg::*;

    issued_instr_t    i_instr;
    reg_data_t        i_data;
    logic [XLEN-1:0]  i_trap_vec;
    logic             o_rf_we;
    logic [4:0]       o_rf_rd;
    logic [XLEN-1:0]  o_rf_data;
    logic             o_flush;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             o_trap_valid;
    logic [XLEN-1:0]  o_epc;
    except_code_t     o_cause;
`ifdef WB_INSTRET_EN
    logic [63:0]      o_instret;
`endif

    modport slave (
`ifdef WB_INSTRET_EN
        output o_instret,
`endif
        input  i_instr, i_data, i_trap_vec,
        output o_rf_we, o_rf_rd, o_rf_data, o_flush, o_redirect_pc,
        output o_trap_valid, o_epc, o_cause
    );

    modport master (
`ifdef WB_INSTRET_EN
        input  o_instret,
`endif
        output i_instr, i_data, i_trap_vec,
        input  o_rf_we, o_rf_rd, o_rf_data, o_flush, o_redirect_pc,
        input  o_trap_valid, o_epc, o_cause
    );
endinterface

// File: rtl/wb_unit.sv
// Writeback/commit stage: register-file write, in-order retire, exception flush/redirect.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module wb_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    wb_unit_if.slave  bus
);
    import wb_unit_pkg::*;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic            trap_valid_q, trap_valid_d;
    logic [XLEN-1:0] epc_q, epc_d;
    except_code_t    cause_q, cause_d;

    always_comb begin
        state_d      = state_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_data_d    = rf_data_q;
        flush_d      = 1'b0;
        redirect_d   = redirect_q;
        trap_valid_d = 1'b0;
        epc_d        = epc_q;
        cause_d      = cause_q;

        case (state_q)
            ST_RUN: begin
                if (bus.i_instr.valid) begin
                    if (!bus.i_instr.except.valid) begin
                        rf_we_d   = bus.i_instr.decode.wb_rd & (bus.i_instr.decode.rd != 5'd0);
                        rf_rd_d   = bus.i_instr.decode.rd;
                        rf_data_d = bus.i_data;
                    end else begin
                        flush_d = 1'b1;
                        state_d = ST_FLUSH;
                        if (bus.i_instr.except.code == EXCEPT_MISPRED) begin
                            redirect_d = bus.i_data;
                        end else begin
                            redirect_d   = {bus.i_trap_vec[XLEN-1:2], 2'b00};
                            epc_d        = bus.i_instr.pc;
                            cause_d      = bus.i_instr.except.code;
                            trap_valid_d = 1'b1;
                        end
                    end
                end
            end
            // Whatever arrives while the flush is in flight is from the squashed path.
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_RUN;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            trap_valid_q <= 1'b0;
            epc_q        <= '0;
            cause_q      <= EXCEPT_NONE;
        end else begin
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            trap_valid_q <= trap_valid_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
        end
    end

    assign bus.o_rf_we       = rf_we_q;
    assign bus.o_rf_rd       = rf_rd_q;
    assign bus.o_rf_data     = rf_data_q;
    assign bus.o_flush       = flush_q;
    assign bus.o_redirect_pc = redirect_q;
    assign bus.o_trap_valid  = trap_valid_q;
    assign bus.o_epc         = epc_q;
    assign bus.o_cause       = cause_q;

`ifdef WB_INSTRET_EN
    logic        retire;
    logic [63:0] instret_q, instret_d;

    // Mispredicted branches retire; real traps do not.
    always_comb begin
        retire = (state_q == ST_RUN) && bus.i_instr.valid &&
                 (!bus.i_instr.except.valid || (bus.i_instr.except.code == EXCEPT_MISPRED));
        instret_d = instret_q + {63'd0, retire};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign bus.o_instret = instret_q;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// Directed self-checking bench for wb_unit; instret checks apply when WB_INSTRET_EN is defined.
module tb_wb_unit;
    import wb_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wb_unit_if #(.XLEN(64)) bus ();

    wb_unit #(.XLEN(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [63:0] pc, input logic [4:0] rd,
                         input logic wb_rd, input logic exc, input except_code_t code,
                         input logic [63:0] data);
        bus.i_instr              = '0;
        bus.i_instr.valid        = valid;
        bus.i_instr.pc           = pc;
        bus.i_instr.decode.rd    = rd;
        bus.i_instr.decode.wb_rd = wb_rd;
        bus.i_instr.except.valid = exc;
        bus.i_instr.except.code  = code;
        bus.i_data               = data;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, EXCEPT_NONE, 64'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_trap_vec = 64'd0;
        idle();
        #12;
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.o_rf_we); end
        checks++; if (bus.o_rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", bus.o_rf_rd); end
        checks++; if (bus.o_rf_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.o_rf_data); end
        checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.o_flush); end
        checks++; if (bus.o_redirect_pc !== 64'd0) begin errors++; $display("FAIL reset_redirect got %h exp 0", bus.o_redirect_pc); end
        checks++; if (bus.o_trap_valid !== 1'b0) begin errors++; $display("FAIL reset_trap_valid got %b exp 0", bus.o_trap_valid); end
        checks++; if (bus.o_epc !== 64'd0) begin errors++; $display("FAIL reset_epc got %h exp 0", bus.o_epc); end
        checks++; if (bus.o_cause !== EXCEPT_NONE) begin errors++; $display("FAIL reset_cause got %0d exp 0", bus.o_cause); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", bus.o_instret); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reg_write();
        drive(1'b1, 64'h8000_0000, 5'd5, 1'b1, 1'b0, EXCEPT_NONE, 64'hDEAD);
        step();
        checks++; if (bus.o_rf_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b exp 1", bus.o_rf_we); end
        checks++; if (bus.o_rf_rd !== 5'd5) begin errors++; $display("FAIL wr_rd got %0d exp 5", bus.o_rf_rd); end
        checks++; if (bus.o_rf_data !== 64'hDEAD) begin errors++; $display("FAIL wr_data got %h exp dead", bus.o_rf_data); end
        checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL wr_flush got %b exp 0", bus.o_flush); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd1) begin errors++; $display("FAIL wr_instret got %0d exp 1", bus.o_instret); end
`endif
        idle();
        step();
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL wr_we_pulse got %b exp 0", bus.o_rf_we); end
    endtask

    task automatic test_x0_write();
        drive(1'b1, 64'h8000_0004, 5'd0, 1'b1, 1'b0, EXCEPT_NONE, 64'h1234);
        step();
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", bus.o_rf_we); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd2) begin errors++; $display("FAIL x0_instret got %0d exp 2", bus.o_instret); end
`endif
        idle();
    endtask

    task automatic test_mispred();
        drive(1'b1, 64'h8000_0008, 5'd0, 1'b0, 1'b1, EXCEPT_MISPRED, 64'h8000_0100);
        step();
        checks++; if (bus.o_flush !== 1'b1) begin errors++; $display("FAIL mp_flush got %b exp 1", bus.o_flush); end
        checks++; if (bus.o_redirect_pc !== 64'h8000_0100) begin errors++; $display("FAIL mp_redirect got %h exp 80000100", bus.o_redirect_pc); end
        checks++; if (bus.o_trap_valid !== 1'b0) begin errors++; $display("FAIL mp_trap_valid got %b exp 0", bus.o_trap_valid); end
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL mp_we got %b exp 0", bus.o_rf_we); end
        checks++; if (bus.o_epc !== 64'd0) begin errors++; $display("FAIL mp_epc got %h exp 0", bus.o_epc); end
        checks++; if (bus.o_cause !== EXCEPT_NONE) begin errors++; $display("FAIL mp_cause got %0d exp 0", bus.o_cause); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd3) begin errors++; $display("FAIL mp_instret got %0d exp 3", bus.o_instret); end
`endif
        idle();
        step();
        checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL mp_flush_pulse got %b exp 0", bus.o_flush); end
    endtask

    task automatic test_trap();
        bus.i_trap_vec = 64'h8000_0203;
        drive(1'b1, 64'h8000_0040, 5'd9, 1'b1, 1'b1, EXCEPT_ILLEGAL, 64'h5555);
        step();
        checks++; if (bus.o_flush !== 1'b1) begin errors++; $display("FAIL trap_flush got %b exp 1", bus.o_flush); end
        checks++; if (bus.o_redirect_pc !== 64'h8000_0200) begin errors++; $display("FAIL trap_redirect got %h exp 80000200", bus.o_redirect_pc); end
        checks++; if (bus.o_epc !== 64'h8000_0040) begin errors++; $display("FAIL trap_epc got %h exp 80000040", bus.o_epc); end
        checks++; if (bus.o_cause !== EXCEPT_ILLEGAL) begin errors++; $display("FAIL trap_cause got %0d exp 2", bus.o_cause); end
        checks++; if (bus.o_trap_valid !== 1'b1) begin errors++; $display("FAIL trap_valid got %b exp 1", bus.o_trap_valid); end
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL trap_we got %b exp 0", bus.o_rf_we); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd3) begin errors++; $display("FAIL trap_instret got %0d exp 3", bus.o_instret); end
`endif
        idle();
        step();
        checks++; if (bus.o_trap_valid !== 1'b0) begin errors++; $display("FAIL trap_valid_pulse got %b exp 0", bus.o_trap_valid); end
        checks++; if (bus.o_epc !== 64'h8000_0040) begin errors++; $display("FAIL trap_epc_hold got %h exp 80000040", bus.o_epc); end
    endtask

    task automatic test_stale_drop();
        bus.i_trap_vec = 64'h0000_2000;
        drive(1'b1, 64'h0000_1000, 5'd0, 1'b0, 1'b1, EXCEPT_ECALL, 64'd0);
        step();
        drive(1'b1, 64'h0000_1004, 5'd3, 1'b1, 1'b0, EXCEPT_NONE, 64'h33);
        step();
        checks++; if (bus.o_rf_we !== 1'b0) begin errors++; $display("FAIL stale_we got %b exp 0", bus.o_rf_we); end
        checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL stale_flush got %b exp 0", bus.o_flush); end
        checks++; if (bus.o_trap_valid !== 1'b0) begin errors++; $display("FAIL stale_trap got %b exp 0", bus.o_trap_valid); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd3) begin errors++; $display("FAIL stale_instret got %0d exp 3", bus.o_instret); end
`endif
        drive(1'b1, 64'h0000_2000, 5'd4, 1'b1, 1'b0, EXCEPT_NONE, 64'h44);
        step();
        checks++; if (bus.o_rf_we !== 1'b1) begin errors++; $display("FAIL after_stale_we got %b exp 1", bus.o_rf_we); end
        checks++; if (bus.o_rf_rd !== 5'd4) begin errors++; $display("FAIL after_stale_rd got %0d exp 4", bus.o_rf_rd); end
        checks++; if (bus.o_rf_data !== 64'h44) begin errors++; $display("FAIL after_stale_data got %h exp 44", bus.o_rf_data); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd4) begin errors++; $display("FAIL after_stale_instret got %0d exp 4", bus.o_instret); end
`endif
        idle();
    endtask

    task automatic test_back_to_back();
        bus.i_trap_vec = 64'h0000_3000;
        drive(1'b1, 64'h0000_2100, 5'd0, 1'b0, 1'b1, EXCEPT_ECALL, 64'd0);
        step();
        drive(1'b1, 64'h0000_2104, 5'd0, 1'b0, 1'b1, EXCEPT_MISPRED, 64'h9999);
        step();
        checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL b2b_flush got %b exp 0", bus.o_flush); end
        checks++; if (bus.o_redirect_pc !== 64'h3000) begin errors++; $display("FAIL b2b_redirect got %h exp 3000", bus.o_redirect_pc); end
        checks++; if (bus.o_epc !== 64'h2100) begin errors++; $display("FAIL b2b_epc got %h exp 2100", bus.o_epc); end
        checks++; if (bus.o_cause !== EXCEPT_ECALL) begin errors++; $display("FAIL b2b_cause got %0d exp 8", bus.o_cause); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd4) begin errors++; $display("FAIL b2b_instret got %0d exp 4", bus.o_instret); end
`endif
        idle();
    endtask

    task automatic test_async_reset();
        bus.i_trap_vec = 64'h0000_4000;
        drive(1'b1, 64'h0000_3100, 5'd0, 1'b0, 1'b1, EXCEPT_BREAKPOINT, 64'd0);
        step();
        idle();
        checks++; if (bus.o_flush !== 1'b1) begin errors++; $display("FAIL ar_pre_flush got %b exp 1", bus.o_flush); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL ar_flush got %b exp 0", bus.o_flush); end
        checks++; if (bus.o_redirect_pc !== 64'd0) begin errors++; $display("FAIL ar_redirect got %h exp 0", bus.o_redirect_pc); end
        checks++; if (bus.o_trap_valid !== 1'b0) begin errors++; $display("FAIL ar_trap_valid got %b exp 0", bus.o_trap_valid); end
        checks++; if (bus.o_epc !== 64'd0) begin errors++; $display("FAIL ar_epc got %h exp 0", bus.o_epc); end
        checks++; if (bus.o_cause !== EXCEPT_NONE) begin errors++; $display("FAIL ar_cause got %0d exp 0", bus.o_cause); end
        checks++; if (bus.o_rf_data !== 64'd0) begin errors++; $display("FAIL ar_data got %h exp 0", bus.o_rf_data); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd0) begin errors++; $display("FAIL ar_instret got %0d exp 0", bus.o_instret); end
`endif
        #3;
        rst_n = 1'b1;
        drive(1'b1, 64'h0000_0100, 5'd7, 1'b1, 1'b0, EXCEPT_NONE, 64'h77);
        step();
        checks++; if (bus.o_rf_we !== 1'b1) begin errors++; $display("FAIL ar_run_we got %b exp 1", bus.o_rf_we); end
        checks++; if (bus.o_rf_rd !== 5'd7) begin errors++; $display("FAIL ar_run_rd got %0d exp 7", bus.o_rf_rd); end
`ifdef WB_INSTRET_EN
        checks++; if (bus.o_instret !== 64'd1) begin errors++; $display("FAIL ar_run_instret got %0d exp 1", bus.o_instret); end
`endif
        idle();
        step();
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret_wrap();
        force dut.instret_q = '1;
        #1;
        release dut.instret_q;
        drive(1'b1, 64'h0000_0200, 5'd1, 1'b1, 1'b0, EXCEPT_NONE, 64'h1);
        step();
        checks++; if (bus.o_instret !== 64'd0) begin errors++; $display("FAIL wrap_instret got %0d exp 0", bus.o_instret); end
        idle();
        step();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reg_write();
        test_x0_write();
        test_mispred();
        test_trap();
        test_stale_drop();
        test_back_to_back();
        test_async_reset();
`ifdef WB_INSTRET_EN
        test_instret_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
